// File: rtl/sru_sched_pkg.sv
// Shared types and defaults for the SRU spike scheduler.
package sru_sched_pkg;

    localparam int unsigned DEF_NUM_IN  = 16;
    localparam int unsigned DEF_W_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        DECAY,
        DONE
    } state_t;

    localparam logic PHASE_EXC = 1'b1;
    localparam logic PHASE_INH = 1'b0;

endpackage

// File: rtl/sru_prio_enc.sv
// Combinational lowest-set-bit finder over the pending-spike candidates.
module sru_prio_enc #(
    parameter int unsigned NUM_IN = 16,
    parameter int unsigned ADDR_W = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    output logic              any,
    output logic [ADDR_W-1:0] idx
);

    // Descending scan so the lowest set index is the final assignment.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/sru_spike_scheduler.sv
// Serialises one timestep's presynaptic spikes into SRU update steps:
// excitatory phase first, then inhibitory, one weight RAM read per spike.
module sru_spike_scheduler
    import sru_sched_pkg::*;
#(
    parameter int unsigned NUM_IN  = DEF_NUM_IN,
    parameter int unsigned W_WIDTH = DEF_W_WIDTH,
    parameter int unsigned ADDR_W  = $clog2(NUM_IN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ts_start,
    input  logic [NUM_IN-1:0]  spike_vec,
    input  logic [NUM_IN-1:0]  exc_mask,
    output logic               w_rd_en,
    output logic [ADDR_W-1:0]  w_addr,
    input  logic [W_WIDTH-1:0] w_rdata,
    output logic               sru_step,
    output logic [W_WIDTH-1:0] sru_wi,
    output logic               sru_E_plus,
    output logic               sru_Ein,
    output logic               busy,
    output logic               done,
    output logic               ts_overrun
);

    state_t              state, state_n;
    logic                phase, phase_n;
    logic                issued, issued_n;
    logic [NUM_IN-1:0]   pend, pend_n;
    logic [NUM_IN-1:0]   emask, emask_n;

    logic                step_n, eplus_n, ein_n, busy_n, done_n, ovr_n;
    logic [W_WIDTH-1:0]  wi_n;
    logic                rd_en_n;
    logic [ADDR_W-1:0]   addr_n;

    logic [NUM_IN-1:0]   cand_n;
    logic                enc_any;
    logic [ADDR_W-1:0]   enc_idx;

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        issued_n = issued;
        pend_n   = pend;
        emask_n  = emask;
        step_n   = 1'b0;
        eplus_n  = 1'b0;
        ein_n    = sru_Ein;
        wi_n     = sru_wi;
        busy_n   = busy;
        done_n   = 1'b0;
        ovr_n    = ts_start && (state != IDLE);

        case (state)
            IDLE: begin
                if (ts_start) begin
                    pend_n   = spike_vec;
                    emask_n  = exc_mask;
                    phase_n  = PHASE_EXC;
                    issued_n = 1'b0;
                    busy_n   = 1'b1;
                    state_n  = SCAN;
                end
            end
            SCAN: begin
                // w_rd_en was registered from this cycle's candidates, so it doubles as "candidate found".
                if (w_rd_en) begin
                    pend_n  = pend & ~(NUM_IN'(1) << w_addr);
                    state_n = ISSUE;
                end else if (!issued) begin
                    state_n = DECAY;
                end else if (phase == PHASE_EXC) begin
                    phase_n  = PHASE_INH;
                    issued_n = 1'b0;
                end else begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            ISSUE: begin
                step_n   = 1'b1;
                eplus_n  = 1'b1;
                ein_n    = phase;
                wi_n     = w_rdata;
                issued_n = 1'b1;
                state_n  = SCAN;
            end
            DECAY: begin
                step_n = 1'b1;
                ein_n  = phase;
                wi_n   = '0;
                if (phase == PHASE_EXC) begin
                    phase_n  = PHASE_INH;
                    issued_n = 1'b0;
                    state_n  = SCAN;
                end else begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Look ahead one cycle so the RAM read strobe is already registered in the SCAN cycle.
    assign cand_n = pend_n & ((phase_n == PHASE_EXC) ? emask_n : ~emask_n);

    sru_prio_enc #(
        .NUM_IN (NUM_IN),
        .ADDR_W (ADDR_W)
    ) u_prio_enc (
        .req (cand_n),
        .any (enc_any),
        .idx (enc_idx)
    );

    assign rd_en_n = (state_n == SCAN) && enc_any;
    assign addr_n  = rd_en_n ? enc_idx : w_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= PHASE_INH;
            issued     <= 1'b0;
            pend       <= '0;
            emask      <= '0;
            w_rd_en    <= 1'b0;
            w_addr     <= '0;
            sru_step   <= 1'b0;
            sru_wi     <= '0;
            sru_E_plus <= 1'b0;
            sru_Ein    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ts_overrun <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            issued     <= issued_n;
            pend       <= pend_n;
            emask      <= emask_n;
            w_rd_en    <= rd_en_n;
            w_addr     <= addr_n;
            sru_step   <= step_n;
            sru_wi     <= wi_n;
            sru_E_plus <= eplus_n;
            sru_Ein    <= ein_n;
            busy       <= busy_n;
            done       <= done_n;
            ts_overrun <= ovr_n;
        end
    end

endmodule

// File: tb/tb_sru_spike_scheduler.sv
// Randomized self-checking bench for sru_spike_scheduler against a spike-list reference model.
module tb_sru_spike_scheduler;

    localparam int unsigned NUM_IN  = 16;
    localparam int unsigned W_WIDTH = 16;
    localparam int unsigned ADDR_W  = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               ts_start;
    logic [NUM_IN-1:0]  spike_vec;
    logic [NUM_IN-1:0]  exc_mask;
    logic               w_rd_en;
    logic [ADDR_W-1:0]  w_addr;
    logic [W_WIDTH-1:0] w_rdata;
    logic               sru_step;
    logic [W_WIDTH-1:0] sru_wi;
    logic               sru_E_plus;
    logic               sru_Ein;
    logic               busy;
    logic               done;
    logic               ts_overrun;

    typedef struct packed {
        logic               eplus;
        logic               ein;
        logic [W_WIDTH-1:0] wi;
    } step_t;

    logic [W_WIDTH-1:0] ram [NUM_IN];
    step_t exp_steps[$];
    step_t obs_steps[$];
    int    exp_addrs[$];
    int    obs_addrs[$];
    int    exp_lat;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    sru_spike_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .ts_start   (ts_start),
        .spike_vec  (spike_vec),
        .exc_mask   (exc_mask),
        .w_rd_en    (w_rd_en),
        .w_addr     (w_addr),
        .w_rdata    (w_rdata),
        .sru_step   (sru_step),
        .sru_wi     (sru_wi),
        .sru_E_plus (sru_E_plus),
        .sru_Ein    (sru_Ein),
        .busy       (busy),
        .done       (done),
        .ts_overrun (ts_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous weight RAM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= ram[w_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: ascending spike lists per phase, a decay step for an empty phase.
    task automatic build_model(input logic [NUM_IN-1:0] sp, input logic [NUM_IN-1:0] mk);
        int n;
        logic p;
        exp_steps.delete();
        exp_addrs.delete();
        exp_lat = 1;
        for (int ph = 1; ph >= 0; ph--) begin
            p = ph[0];
            n = 0;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (sp[i] && (mk[i] == p)) begin
                    exp_addrs.push_back(i);
                    exp_steps.push_back('{eplus: 1'b1, ein: p, wi: ram[i]});
                    n++;
                end
            end
            if (n == 0) exp_steps.push_back('{eplus: 1'b0, ein: p, wi: '0});
            exp_lat += (n > 0) ? 2 * n + 1 : 2;
        end
    endtask

    task automatic run_ts(input string name, input logic [NUM_IN-1:0] sp,
                          input logic [NUM_IN-1:0] mk, input bit do_ovr);
        int t0, done_at, done_cnt, ovr_cnt, busy_cnt;
        build_model(sp, mk);
        obs_steps.delete();
        obs_addrs.delete();
        done_at  = -1;
        done_cnt = 0;
        ovr_cnt  = 0;
        busy_cnt = 0;
        @(negedge clk);
        spike_vec = sp;
        exc_mask  = mk;
        ts_start  = 1'b1;
        t0        = cyc;
        @(negedge clk);
        ts_start  = 1'b0;
        spike_vec = NUM_IN'($urandom);
        exc_mask  = NUM_IN'($urandom);
        for (int k = 0; k < 300; k++) begin
            if (sru_step) obs_steps.push_back('{eplus: sru_E_plus, ein: sru_Ein, wi: sru_wi});
            if (w_rd_en) obs_addrs.push_back(int'(w_addr));
            if (busy) busy_cnt++;
            if (ts_overrun) ovr_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc - t0;
            end
            if (done_at >= 0 && (cyc - t0) >= done_at + 2) break;
            ts_start = do_ovr && ((cyc - t0) == 3 || (cyc - t0) == exp_lat);
            @(negedge clk);
        end
        ts_start = 1'b0;
        check_val({name, "_latency"}, 32'(done_at), 32'(exp_lat));
        check_val({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check_val({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check_val({name, "_overruns"}, 32'(ovr_cnt), do_ovr ? 32'd2 : 32'd0);
        check_val({name, "_n_steps"}, 32'(obs_steps.size()), 32'(exp_steps.size()));
        for (int k = 0; k < exp_steps.size() && k < obs_steps.size(); k++)
            check_val($sformatf("%s_step%0d", name, k), 32'(obs_steps[k]), 32'(exp_steps[k]));
        check_val({name, "_n_reads"}, 32'(obs_addrs.size()), 32'(exp_addrs.size()));
        for (int k = 0; k < exp_addrs.size() && k < obs_addrs.size(); k++)
            check_val($sformatf("%s_addr%0d", name, k), 32'(obs_addrs[k]), 32'(exp_addrs[k]));
    endtask

    initial begin
        reset     = 1'b1;
        ts_start  = 1'b0;
        spike_vec = '0;
        exc_mask  = '0;
        w_rdata   = '0;
        for (int i = 0; i < int'(NUM_IN); i++) ram[i] = W_WIDTH'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_step", 32'(sru_step), 32'd0);
        check_val("rst_rd_en", 32'(w_rd_en), 32'd0);
        check_val("rst_overrun", 32'(ts_overrun), 32'd0);
        check_val("rst_wi", 32'(sru_wi), 32'd0);
        reset = 1'b0;

        run_ts("empty", 16'h0000, 16'h1234, 1'b0);
        ram[0] = 16'd3;
        ram[2] = 16'd7;
        run_ts("exc_only", 16'h0005, 16'hFFFF, 1'b0);
        run_ts("mixed", 16'h8001, 16'h0001, 1'b0);
        run_ts("overrun", NUM_IN'($urandom), NUM_IN'($urandom), 1'b1);
        run_ts("after_ovr", NUM_IN'($urandom), NUM_IN'($urandom), 1'b0);

        // Reset mid-timestep: outputs clear at once and no done follows.
        @(negedge clk);
        spike_vec = 16'h00F0;
        exc_mask  = 16'hFFFF;
        ts_start  = 1'b1;
        @(negedge clk);
        ts_start = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_val("midrst_step", 32'(sru_step), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_rd_en", 32'(w_rd_en), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_val("postrst_idle", 32'({busy, done, sru_step}), 32'd0);
        end
        run_ts("post_rst", NUM_IN'($urandom), NUM_IN'($urandom), 1'b0);

        run_ts("full", 16'hFFFF, 16'hAAAA, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < int'(NUM_IN); i++) ram[i] = W_WIDTH'($urandom);
            run_ts($sformatf("rand%0d", r), NUM_IN'($urandom), NUM_IN'($urandom), r[2]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
